// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern sequencer.
//   state_t     : sequencer FSM states
//   SYM_W       : width of a stored symbol (symbols 0..2)
//   LED_W       : width of the one-hot LED display
//   sym_onehot  : symbol -> one-hot LED pattern
package pattern_seq_pkg;

    localparam int SYM_W = 2;
    localparam int LED_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        PLAY_ON,
        PLAY_OFF,
        DONE
    } state_t;

    function automatic logic [LED_W-1:0] sym_onehot(input logic [SYM_W-1:0] s);
        return LED_W'(1) << s;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Loadable down-counter timing the lit and dark periods of playback.
//   clk, reset   : clock, synchronous active-low reset
//   load         : load load_val this cycle (wins over counting)
//   load_val     : period length minus one
//   expired      : count has reached zero (last cycle of the period)
module seq_step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pattern_sequencer.sv
// Memory-game pattern sequencer: stores a growing list of random symbols and
// plays them back on a one-hot LED display with fixed lit/dark timing.
//   clk, reset  : clock, synchronous active-low reset
//   rand_in     : upstream random symbol (3 is folded to 0)
//   start       : new game (clear, append one, play)
//   next_round  : append one (skipped when full), play
//   replay      : (only with PATTERN_SEQ_REPLAY_EN) play without appending
//   rd_idx/rd_data : combinational read port for the input checker
//   led_out, seq_len, busy, full, play_done : registered status/display
// Optional feature macro: PATTERN_SEQ_REPLAY_EN
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int MAX_LEN    = 8,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] rand_in,
    input  logic             start,
    input  logic             next_round,
`ifdef PATTERN_SEQ_REPLAY_EN
    input  logic             replay,
`endif
    input  logic [3:0]       rd_idx,
    output logic [SYM_W-1:0] rd_data,
    output logic [LED_W-1:0] led_out,
    output logic [3:0]       seq_len,
    output logic             busy,
    output logic             full,
    output logic             play_done
);

    localparam int         AW        = $clog2(MAX_LEN);
    localparam int         TW        = 16;
    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_t           state;
    logic [3:0]       play_idx;
    logic [SYM_W-1:0] mem [MAX_LEN];

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_exp;

    logic [SYM_W-1:0] new_sym;
    logic             go_start, go_next, go_replay, go_direct, last_step;

    assign new_sym   = (rand_in == 2'd3) ? '0 : rand_in;
    assign go_start  = (state == IDLE) && start;
    assign go_next   = (state == IDLE) && !start && next_round;
`ifdef PATTERN_SEQ_REPLAY_EN
    assign go_replay = (state == IDLE) && !start && !next_round && replay && (seq_len != 4'd0);
`else
    assign go_replay = 1'b0;
`endif
    // Paths that skip APPEND and start lighting on the next cycle.
    assign go_direct = (go_next && full) || go_replay;
    assign last_step = (play_idx == seq_len - 4'd1);

    assign rd_data = (rd_idx < seq_len) ? mem[AW'(rd_idx)] : '0;

    // Timer is loaded on every entry into a lit or dark period.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE:     if (go_direct)               begin tmr_load = 1'b1; tmr_val = TW'(ON_CYCLES - 1);  end
            APPEND:                                begin tmr_load = 1'b1; tmr_val = TW'(ON_CYCLES - 1);  end
            PLAY_ON:  if (tmr_exp)                 begin tmr_load = 1'b1; tmr_val = TW'(OFF_CYCLES - 1); end
            PLAY_OFF: if (tmr_exp && !last_step)   begin tmr_load = 1'b1; tmr_val = TW'(ON_CYCLES - 1);  end
            default: ;
        endcase
    end

    seq_step_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Memory has no reset; reads above seq_len are masked instead.
    always_ff @(posedge clk) begin
        if (reset && state == APPEND)
            mem[AW'(seq_len)] <= new_sym;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            seq_len   <= '0;
            play_idx  <= '0;
            led_out   <= '0;
            busy      <= 1'b0;
            full      <= 1'b0;
            play_done <= 1'b0;
        end else begin
            play_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_start) begin
                        seq_len <= '0;
                        full    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= APPEND;
                    end else if (go_direct) begin
                        busy     <= 1'b1;
                        play_idx <= '0;
                        led_out  <= sym_onehot(mem[0]);
                        state    <= PLAY_ON;
                    end else if (go_next) begin
                        busy  <= 1'b1;
                        state <= APPEND;
                    end
                end
                APPEND: begin
                    seq_len  <= seq_len + 4'd1;
                    full     <= (seq_len + 4'd1) == MAX_LEN_L;
                    play_idx <= '0;
                    // mem[0] is being written this edge when the list was empty.
                    led_out  <= sym_onehot((seq_len == 4'd0) ? new_sym : mem[0]);
                    state    <= PLAY_ON;
                end
                PLAY_ON: begin
                    if (tmr_exp) begin
                        led_out <= '0;
                        state   <= PLAY_OFF;
                    end
                end
                PLAY_OFF: begin
                    if (tmr_exp) begin
                        if (last_step) begin
                            play_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            play_idx <= play_idx + 4'd1;
                            led_out  <= sym_onehot(mem[AW'(play_idx + 4'd1)]);
                            state    <= PLAY_ON;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    localparam int MAX_LEN = 8;
    localparam int ON_C    = 4;
    localparam int OFF_C   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rand_in = '0;
    logic       start = 1'b0;
    logic       next_round = 1'b0;
`ifdef PATTERN_SEQ_REPLAY_EN
    logic       replay = 1'b0;
`endif
    logic [3:0] rd_idx = '0;
    logic [1:0] rd_data;
    logic [2:0] led_out;
    logic [3:0] seq_len;
    logic       busy, full, play_done;

    int checks = 0;
    int failures = 0;

    // Reference: the stored game sequence as a plain list of symbols.
    int model[$];

    pattern_sequencer #(.MAX_LEN(MAX_LEN), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
        .clk        (clk),
        .reset      (reset),
        .rand_in    (rand_in),
        .start      (start),
        .next_round (next_round),
`ifdef PATTERN_SEQ_REPLAY_EN
        .replay     (replay),
`endif
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .led_out    (led_out),
        .seq_len    (seq_len),
        .busy       (busy),
        .full       (full),
        .play_done  (play_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 start, 1 next_round, 2 start+next_round, 3 replay.
    // noise: toggle start/next_round randomly while busy (must be ignored).
    task automatic run_cmd(input int kind, input logic [1:0] sym_in, input bit noise);
        int   sym;
        bit   append;
        int   exp_led[$];
        int   exp_done[$];
        int   cyc;
        sym = (sym_in == 2'd3) ? 0 : int'(sym_in);
        append = 1'b0;
        if (kind == 0 || kind == 2) begin
            model.delete();
            model.push_back(sym);
            append = 1'b1;
        end else if (kind == 1 && model.size() < MAX_LEN) begin
            model.push_back(sym);
            append = 1'b1;
        end
        rand_in    = sym_in;
        start      = (kind == 0 || kind == 2);
        next_round = (kind == 1 || kind == 2);
`ifdef PATTERN_SEQ_REPLAY_EN
        replay     = (kind == 3);
`endif
        step();
        start = 1'b0;
        next_round = 1'b0;
`ifdef PATTERN_SEQ_REPLAY_EN
        replay = 1'b0;
`endif
        if (append) begin exp_led.push_back(0); exp_done.push_back(0); end
        foreach (model[k]) begin
            for (int c = 0; c < ON_C; c++)  begin exp_led.push_back(1 << model[k]); exp_done.push_back(0); end
            for (int c = 0; c < OFF_C; c++) begin exp_led.push_back(0); exp_done.push_back(0); end
        end
        exp_led.push_back(0); exp_done.push_back(1);
        cyc = 0;
        foreach (exp_led[i]) begin
            checks++;
            if (led_out !== 3'(exp_led[i]) || play_done !== 1'(exp_done[i]) || busy !== 1'b1) begin
                failures++;
                $display("FAIL play_k%0d_c%0d: led=%b done=%b busy=%b expected led=%b done=%0d busy=1",
                         kind, cyc, led_out, play_done, busy, 3'(exp_led[i]), exp_done[i]);
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                next_round = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        start = 1'b0;
        next_round = 1'b0;
        checks++;
        if (busy !== 1'b0 || play_done !== 1'b0 || led_out !== 3'b000 ||
            seq_len !== 4'(model.size()) || full !== (model.size() == MAX_LEN)) begin
            failures++;
            $display("FAIL idle_after_k%0d: busy=%b done=%b led=%b len=%0d full=%b expected 0 0 000 len=%0d full=%0d",
                     kind, busy, play_done, led_out, seq_len, full, model.size(), model.size() == MAX_LEN);
        end
        for (int idx = 0; idx < 16; idx++) begin
            rd_idx = 4'(idx);
            #1;
            checks++;
            if (rd_data !== 2'(idx < model.size() ? model[idx] : 0)) begin
                failures++;
                $display("FAIL rd_data_idx%0d: got %0d expected %0d", idx, rd_data,
                         idx < model.size() ? model[idx] : 0);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        model.delete();
        rd_idx = 4'd0;
        #1;
        checks++;
        if (led_out !== 3'b000 || busy !== 1'b0 || full !== 1'b0 || play_done !== 1'b0 ||
            seq_len !== 4'd0 || rd_data !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: led=%b busy=%b full=%b done=%b len=%0d rd=%0d expected all 0",
                     led_out, busy, full, play_done, seq_len, rd_data);
        end
    endtask

    task automatic test_first_start();
        run_cmd(0, 2'd2, 1'b0);
        checks++;
        if (seq_len !== 4'd1) begin
            failures++;
            $display("FAIL first_start_len: got %0d expected 1", seq_len);
        end
    endtask

    task automatic test_next_rounds();
        run_cmd(1, 2'd0, 1'b0);
        run_cmd(1, 2'd1, 1'b0);
        run_cmd(1, 2'd2, 1'b0);
        rd_idx = 4'd2;
        #1;
        checks++;
        if (seq_len !== 4'd4 || rd_data !== 2'd1) begin
            failures++;
            $display("FAIL next_rounds: len=%0d rd2=%0d expected len=4 rd2=1", seq_len, rd_data);
        end
    endtask

    task automatic test_fill_full();
        while (model.size() < MAX_LEN)
            run_cmd(1, 2'($urandom_range(0, 3)), 1'b1);
        run_cmd(1, 2'($urandom_range(0, 3)), 1'b0);
        checks++;
        if (full !== 1'b1 || seq_len !== 4'd8) begin
            failures++;
            $display("FAIL full_next_round: full=%b len=%0d expected full=1 len=8", full, seq_len);
        end
    endtask

    task automatic test_start_wins();
        run_cmd(0, 2'($urandom_range(0, 3)), 1'b0);
        run_cmd(1, 2'($urandom_range(0, 3)), 1'b0);
        run_cmd(1, 2'($urandom_range(0, 3)), 1'b0);
        run_cmd(2, 2'($urandom_range(0, 3)), 1'b1);
        checks++;
        if (seq_len !== 4'd1) begin
            failures++;
            $display("FAIL start_wins_len: got %0d expected 1", seq_len);
        end
        run_cmd(0, 2'd3, 1'b0);
        rd_idx = 4'd0;
        #1;
        checks++;
        if (rd_data !== 2'd0) begin
            failures++;
            $display("FAIL sym3_stored: got %0d expected 0", rd_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            run_cmd(($urandom_range(0, 3) == 0) ? 0 : 1, 2'($urandom_range(0, 3)), 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [1:0] s;
        run_cmd(0, 2'($urandom_range(0, 2)), 1'b0);
        s = 2'($urandom_range(0, 2));
        rand_in = s;
        next_round = 1'b1;
        step();
        next_round = 1'b0;
        model.push_back(int'(s));
        // cycle 1 is APPEND; cycle 1 + ON + OFF + 1 is the second lit step
        for (int c = 0; c < ON_C + OFF_C + 1; c++) step();
        checks++;
        if (led_out !== 3'(1 << model[1])) begin
            failures++;
            $display("FAIL mid_second_step: led=%b expected %b", led_out, 3'(1 << model[1]));
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        model.delete();
        checks++;
        if (led_out !== 3'b000 || busy !== 1'b0 || seq_len !== 4'd0 || play_done !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: led=%b busy=%b len=%0d done=%b full=%b expected all 0",
                     led_out, busy, seq_len, play_done, full);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (play_done !== 1'b0 || busy !== 1'b0 || led_out !== 3'b000) begin
                failures++;
                $display("FAIL post_reset_quiet_c%0d: done=%b busy=%b led=%b expected 0", c, play_done, busy, led_out);
            end
        end
    endtask

`ifdef PATTERN_SEQ_REPLAY_EN
    task automatic test_replay();
        run_cmd(0, 2'($urandom_range(0, 3)), 1'b0);
        run_cmd(1, 2'($urandom_range(0, 3)), 1'b0);
        run_cmd(3, 2'($urandom_range(0, 3)), 1'b1);
        checks++;
        if (seq_len !== 4'd2) begin
            failures++;
            $display("FAIL replay_len: got %0d expected 2", seq_len);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_start();
        test_next_rounds();
        test_fill_full();
        test_start_wins();
        test_random();
        test_reset_mid();
`ifdef PATTERN_SEQ_REPLAY_EN
        test_replay();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 8: sequence memory depth in entries (2..15).
REQ-002 Parameter ON_CYCLES, default 4: clk cycles each LED stays lit during playback (>=1).
REQ-003 Parameter OFF_CYCLES, default 2: dark gap cycles after each lit step (>=1).
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 rand_in  input  2  random symbol from the upstream random number generator (legal 0..2).
REQ-007 start  input  1  new game: clear sequence, append one symbol, play.
REQ-008 next_round  input  1  append one symbol to the existing sequence, then play.
REQ-009 rd_idx  input  4  read index for the downstream input checker.
REQ-010 rd_data  output  2  stored symbol at rd_idx, combinational; 0 when rd_idx >= seq_len.
REQ-011 led_out  output  3  one-hot playback display; bit n lit for symbol n; 3'b000 when dark.
REQ-012 seq_len  output  4  number of valid stored symbols.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 full  output  1  high when seq_len == MAX_LEN.
REQ-015 play_done  output  1  one-cycle pulse when playback completes.

Function
REQ-016 FSM states SHALL be IDLE, APPEND, PLAY_ON, PLAY_OFF, DONE.
REQ-017 IDLE + start: seq_len cleared to 0; next state APPEND.
REQ-018 IDLE + next_round (start low): next state APPEND; if full, APPEND is skipped and next state is PLAY_ON.
REQ-019 start and next_round high in the same cycle: start wins.
REQ-020 start/next_round while busy SHALL be ignored (not queued).
REQ-021 APPEND: rand_in sampled and written to mem[seq_len], seq_len incremented; lasts exactly 1 cycle; next PLAY_ON with play index 0.
REQ-022 rand_in == 3 SHALL be stored as 0.
REQ-023 PLAY_ON: led_out = one-hot of mem[play index] for exactly ON_CYCLES cycles, then PLAY_OFF.
REQ-024 PLAY_OFF: led_out = 0 for exactly OFF_CYCLES cycles; then if play index == seq_len-1, go to DONE, else increment play index and go to PLAY_ON.
REQ-025 DONE: play_done high for exactly 1 cycle, led_out = 0; next IDLE.
REQ-026 Latency: start sampled in cycle 0 -> APPEND in cycle 1 -> first LED lit in cycle 2; play_done in cycle 1 + seq_len*(ON_CYCLES+OFF_CYCLES) + 1.
REQ-027 seq_len SHALL never exceed MAX_LEN; memory contents are retained in IDLE and DONE.
REQ-028 All outputs except rd_data SHALL be registered.

Reset
REQ-029 reset low at a clock edge: state IDLE, seq_len 0, led_out 0, busy 0, full 0, play_done 0, play index and timer 0, from the next cycle, including mid-playback.
REQ-030 Memory contents need not be cleared; rd_data reads 0 after reset via REQ-010.

Configuration
REQ-031 Macro PATTERN_SEQ_REPLAY_EN: when defined, adds input replay (1 bit); IDLE + replay (start, next_round low) with seq_len > 0 goes directly to PLAY_ON without appending; replay has lowest priority.
REQ-032 Without PATTERN_SEQ_REPLAY_EN, the replay port SHALL not exist and behaviour is exactly REQ-016..REQ-028.

Structure
REQ-033 Shared package pattern_seq_pkg SHALL hold the state enum typedef, the symbol width constant (2), and the LED width constant (3).
REQ-034 One sub-module, seq_step_timer: loadable down-counter signalling expiry for ON/OFF periods; no other sub-modules.

Verification
REQ-035 Reset, then start with rand_in=2 -> APPEND cycle 1, led_out=3'b100 in cycles 2-5, 0 in cycles 6-7, play_done in cycle 8, seq_len=1.
REQ-036 Three next_rounds with rand_in 0,1,2 after REQ-035 -> seq_len=4; playback order 100,001,010,100; rd_idx=2 gives rd_data=1.
REQ-037 Fill to MAX_LEN=8, then next_round -> full=1, seq_len stays 8, playback of 8 steps, no memory write.
REQ-038 start and next_round in same cycle after seq_len=3 -> seq_len=1 after APPEND; start during PLAY_ON ignored.
REQ-039 reset low during second PLAY_ON step -> next cycle led_out=0, busy=0, seq_len=0, no play_done pulse.
REQ-040 With PATTERN_SEQ_REPLAY_EN, seq_len=2, replay -> first LED next cycle, seq_len unchanged, play_done after 2*(4+2)+1 cycles; rand_in=3 on start stores 0.
